// File: rtl/gpu_isa_pkg.sv
// gpu_isa_pkg -- shared definitions for the GPU load/store path.
//
// Contents:
//   lsu_state_t : sequencer FSM state (IDLE, REQ, RESP, DONE)
//   LSU_DEF_*   : default lane count and address/data width
//   idx_width() : bit width needed to index n lanes (at least 1)
package gpu_isa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  localparam int LSU_DEF_THREADS = 4;
  localparam int LSU_DEF_WIDTH   = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsu_mem_sequencer_if.sv
// lsu_mem_sequencer_if -- bundle of the core-side warp request port and the
// single memory port of the load/store sequencer.
//
// Handshakes:
//   Core side : a request transfers on a rising edge where req_valid and
//               req_ready are both 1; req_ready is 1 only while idle and a
//               request seen while busy is dropped, not queued.
//   Mem side  : a beat transfers on a rising edge where mem_valid and
//               mem_ready are both 1; mem_addr/mem_wdata/mem_we are held
//               stable from mem_valid rising until that edge. A load beat is
//               answered later by one cycle of mem_rvalid with mem_rdata.
//
// Modports: slave  = the sequencer
//           master = the core/memory environment driving it
// dbg_state exposes the sequencer FSM state.
import gpu_isa_pkg::*;

interface lsu_mem_sequencer_if #(
  parameter int NUM_THREADS = LSU_DEF_THREADS,
  parameter int DATA_WIDTH  = LSU_DEF_WIDTH
);
  logic                                  req_valid;
  logic                                  req_we;
  logic [NUM_THREADS-1:0]                req_mask;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] lane_addr;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] lane_wdata;
  logic                                  req_ready;
  logic                                  stall;
  logic                                  done;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] lane_rdata;

  logic                                  mem_valid;
  logic                                  mem_ready;
  logic [DATA_WIDTH-1:0]                 mem_addr;
  logic [DATA_WIDTH-1:0]                 mem_wdata;
  logic                                  mem_we;
  logic                                  mem_rvalid;
  logic [DATA_WIDTH-1:0]                 mem_rdata;

  lsu_state_t                            dbg_state;

  modport slave (
    input  req_valid, req_we, req_mask, lane_addr, lane_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, stall, done, lane_rdata,
    output mem_valid, mem_addr, mem_wdata, mem_we,
    output dbg_state
  );

  modport master (
    output req_valid, req_we, req_mask, lane_addr, lane_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, stall, done, lane_rdata,
    input  mem_valid, mem_addr, mem_wdata, mem_we,
    input  dbg_state
  );
endinterface

// File: rtl/lsu_mem_sequencer_lane_pick.sv
// lane_pick -- lowest-set-bit selector over a pending-lane mask.
//
// Ports:
//   i_mask : pending lanes, bit t = lane t still needs service
//   o_idx  : index of the lowest set bit (0 when the mask is empty)
//   o_any  : 1 when any bit of i_mask is set
module lane_pick
  import gpu_isa_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_mask,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_mask;
    // Scan downward so the lowest set bit is the last one written.
    for (int t = N - 1; t >= 0; t--) begin
      if (i_mask[t]) o_idx = IW'(t);
    end
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer -- serialises a SIMT warp LDR/STR into single-lane
// accesses on one memory port, lowest active lane first.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : lsu_mem_sequencer_if.slave (core request, memory port,
//                FSM debug state)
//
// Optional feature: define LSU_COALESCE_EN to let one load response fill
// every pending lane that latched the same address as the served lane.
module lsu_mem_sequencer
  import gpu_isa_pkg::*;
#(
  parameter int NUM_THREADS = LSU_DEF_THREADS,
  parameter int DATA_WIDTH  = LSU_DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsu_mem_sequencer_if.slave   bus
);

  localparam int IW = idx_width(NUM_THREADS);
  typedef logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] lane_vec_t;

  lsu_state_t             r_state;
  logic                   r_we;
  logic [NUM_THREADS-1:0] r_pending;
  lane_vec_t              r_addr;
  lane_vec_t              r_wdata;
  lane_vec_t              r_rdata;
  logic [IW-1:0]          r_lane;
  logic                   r_req_ready;
  logic                   r_stall;
  logic                   r_done;
  logic                   r_mem_valid;
  logic                   r_mem_we;
  logic [DATA_WIDTH-1:0]  r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;

  logic [NUM_THREADS-1:0] w_lane_oh;
  logic [NUM_THREADS-1:0] w_clr_mask;
  logic [NUM_THREADS-1:0] w_pend_nxt;
  lane_vec_t              w_addr_src;
  lane_vec_t              w_wdata_src;
  logic                   w_advance;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_any;

  // Lanes retired by the current load response.
  always_comb begin
    w_lane_oh  = '0;
    w_clr_mask = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_lane_oh[t] = (IW'(t) == r_lane);
`ifdef LSU_COALESCE_EN
      w_clr_mask[t] = r_pending[t] && (r_addr[t] == r_addr[r_lane]);
`else
      w_clr_mask[t] = (IW'(t) == r_lane);
`endif
    end
  end

  // w_advance marks the cycles where the pending mask changes and the next
  // lane (or DONE) must be chosen. On acceptance the lane data is taken
  // straight from the request since it is not latched yet.
  always_comb begin
    w_advance   = 1'b0;
    w_pend_nxt  = r_pending;
    w_addr_src  = r_addr;
    w_wdata_src = r_wdata;
    case (r_state)
      ST_IDLE: begin
        w_addr_src  = bus.lane_addr;
        w_wdata_src = bus.lane_wdata;
        if (bus.req_valid) begin
          w_advance  = 1'b1;
          w_pend_nxt = bus.req_mask;
        end
      end
      ST_REQ: begin
        if (bus.mem_ready && r_we) begin
          w_advance  = 1'b1;
          w_pend_nxt = r_pending & ~w_lane_oh;
        end
      end
      ST_RESP: begin
        if (bus.mem_rvalid) begin
          w_advance  = 1'b1;
          w_pend_nxt = r_pending & ~w_clr_mask;
        end
      end
      default: ;
    endcase
  end

  lane_pick #(.N(NUM_THREADS)) u_lane_pick (
    .i_mask (w_pend_nxt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_pending   <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_lane      <= '0;
      r_req_ready <= 1'b1;
      r_stall     <= 1'b0;
      r_done      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_mem_we    <= bus.req_we;
            r_addr      <= bus.lane_addr;
            r_wdata     <= bus.lane_wdata;
            r_req_ready <= 1'b0;
            r_stall     <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            if (!r_we) r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.mem_rvalid) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
              if (w_clr_mask[t]) r_rdata[t] <= bus.mem_rdata;
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_stall     <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Issue the next beat with registered address/data, or finish.
      if (w_advance) begin
        r_pending <= w_pend_nxt;
        if (w_pick_any) begin
          r_state     <= ST_REQ;
          r_mem_valid <= 1'b1;
          r_lane      <= w_pick_idx;
          r_mem_addr  <= w_addr_src[w_pick_idx];
          r_mem_wdata <= w_wdata_src[w_pick_idx];
        end else begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.stall      = r_stall;
  assign bus.done       = r_done;
  assign bus.lane_rdata = r_rdata;
  assign bus.mem_valid  = r_mem_valid;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb_lsu_mem_sequencer -- self-checking bench for lsu_mem_sequencer.
// A memory responder with programmable ready/response waits serves the
// port; a reference model predicts beats, lane results and latency.
// Honours LSU_COALESCE_EN in the same way as the design.
module tb_lsu_mem_sequencer;
  import gpu_isa_pkg::*;

  localparam int NT = 4;
  localparam int DW = 16;
  localparam int BW = 1 + 2 * DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  lsu_mem_sequencer_if #(.NUM_THREADS(NT), .DATA_WIDTH(DW)) bus();

  lsu_mem_sequencer #(.NUM_THREADS(NT), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_rd  [NT];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];

  int   ready_wait = 0;
  int   resp_wait  = 0;
  bit   resp_pend  = 1'b0;
  int   resp_cnt   = 0;
  int   rdy_cnt    = 0;
  logic [DW-1:0] resp_data = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_rd();
    logic [63:0] r;
    r = '0;
    for (int t = 0; t < NT; t++) r[t*DW +: DW] = exp_rd[t];
    return r;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (resp_pend) begin
        if (resp_cnt >= resp_wait) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = resp_data;
          resp_pend      = 1'b0;
        end else begin
          resp_cnt++;
        end
      end
      bus.mem_ready = 1'b0;
      if (bus.mem_valid === 1'b1 && rst_n === 1'b1) begin
        if (rdy_cnt >= ready_wait) begin
          // Beat transfers at the coming rising edge.
          bus.mem_ready = 1'b1;
          rdy_cnt       = 0;
          got_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
          if (bus.mem_we) begin
            mem_arr[bus.mem_addr[7:0]] = bus.mem_wdata;
          end else begin
            resp_pend = 1'b1;
            resp_cnt  = 0;
            resp_data = mem_arr[bus.mem_addr[7:0]];
          end
        end else begin
          rdy_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic init_mem();
    for (int a = 0; a < 256; a++) begin
      mem_arr[a] = DW'(a + 10);
      ref_mem[a] = DW'(a + 10);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_mask   = '0;
    bus.lane_addr  = '0;
    bus.lane_wdata = '0;
  endtask

  // One warp request: predict, drive, follow to done, compare.
  task automatic do_txn(input logic we, input logic [NT-1:0] mask,
                        input logic [NT*DW-1:0] addr, input logic [NT*DW-1:0] wdata,
                        input int rw, input int sw, input bit hold,
                        input bit use_tab, input logic [63:0] tab_rd,
                        input int tab_lat, input int tab_beats, input string tag);
    int exp_lat;
    int cyc;
    bit stall_ok, stable_ok, done_seen, prev_stalled, merged;
    logic [DW-1:0] a, d, p_addr, p_wdata;
    logic p_we;
    logic [DW-1:0] seen[$];
    int n;

    // Reference model: lanes in ascending order, one beat per lane, or per
    // distinct address for coalesced loads.
    exp_q.delete();
    exp_lat = 1;
    for (int t = 0; t < NT; t++) begin
      if (mask[t]) begin
        a = addr[t*DW +: DW];
        d = wdata[t*DW +: DW];
        if (we) begin
          exp_q.push_back({1'b1, a, d});
          ref_mem[a[7:0]] = d;
          exp_lat += 1 + rw;
        end else begin
          merged = 1'b0;
`ifdef LSU_COALESCE_EN
          foreach (seen[i]) if (seen[i] == a) merged = 1'b1;
`endif
          if (!merged) begin
            exp_q.push_back({1'b0, a, d});
            seen.push_back(a);
            exp_lat += 2 + rw + sw;
          end
          exp_rd[t] = ref_mem[a[7:0]];
        end
      end
    end

    ready_wait = rw;
    resp_wait  = sw;
    got_q.delete();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_mask   = mask;
    bus.lane_addr  = addr;
    bus.lane_wdata = wdata;
    #1;
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);

    cyc = 0; stall_ok = 1'b1; stable_ok = 1'b1; done_seen = 1'b0; prev_stalled = 1'b0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      if (hold) begin
        // A different request held during busy must be dropped.
        bus.req_we    = ~we;
        bus.req_mask  = ~mask;
        bus.lane_addr = {$urandom, $urandom};
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      cyc++;
      if (bus.stall !== 1'b1 || bus.req_ready !== 1'b0) stall_ok = 1'b0;
      if (prev_stalled && (bus.mem_valid !== 1'b1 || bus.mem_addr !== p_addr ||
                           bus.mem_wdata !== p_wdata || bus.mem_we !== p_we))
        stable_ok = 1'b0;
      prev_stalled = (bus.mem_valid === 1'b1) && (bus.mem_ready === 1'b0);
      p_addr  = bus.mem_addr;
      p_wdata = bus.mem_wdata;
      p_we    = bus.mem_we;
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    bus.req_valid = 1'b0;

    chk({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(use_tab ? tab_lat : exp_lat));
    chk({tag, "_beats"}, 64'(got_q.size()), 64'(use_tab ? tab_beats : exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_rdata"}, 64'(bus.lane_rdata), use_tab ? tab_rd : pack_rd());
    chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_mem_stable"}, 64'(stable_ok), 64'd1);

    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_idle_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_idle_stall"}, 64'(bus.stall), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          we;
    logic [NT-1:0] mask;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    int            rw;
    bit            hold;
    logic [63:0]   rd;
    int            lat;
    int            beats;
  } vec_t;

  vec_t tab[6];

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int reached;

    tab[0] = '{1'b0, 4'b1111, {16'd3, 16'd2, 16'd1, 16'd0}, 64'd0, 0, 1'b0,
               {16'd13, 16'd12, 16'd11, 16'd10}, 9, 4};
    tab[1] = '{1'b1, 4'b0010, {16'd0, 16'd0, 16'd5, 16'd0}, {16'd0, 16'd0, 16'd22, 16'd0},
               0, 1'b0, {16'd13, 16'd12, 16'd11, 16'd10}, 2, 1};
    tab[2] = '{1'b0, 4'b0000, {16'd9, 16'd9, 16'd9, 16'd9}, 64'd0, 0, 1'b0,
               {16'd13, 16'd12, 16'd11, 16'd10}, 1, 0};
    tab[3] = '{1'b0, 4'b0010, {16'd0, 16'd0, 16'd5, 16'd0}, 64'd0, 0, 1'b0,
               {16'd13, 16'd12, 16'd22, 16'd10}, 3, 1};
`ifdef LSU_COALESCE_EN
    tab[4] = '{1'b0, 4'b1111, {16'd7, 16'd7, 16'd7, 16'd7}, 64'd0, 0, 1'b0,
               {16'd17, 16'd17, 16'd17, 16'd17}, 3, 1};
`else
    tab[4] = '{1'b0, 4'b1111, {16'd7, 16'd7, 16'd7, 16'd7}, 64'd0, 0, 1'b0,
               {16'd17, 16'd17, 16'd17, 16'd17}, 9, 4};
`endif
    tab[5] = '{1'b0, 4'b1111, {16'd43, 16'd42, 16'd41, 16'd40}, 64'd0, 3, 1'b1,
               {16'd53, 16'd52, 16'd51, 16'd50}, 21, 4};

    init_mem();
    idle_inputs();
    for (int t = 0; t < NT; t++) exp_rd[t] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_stall", 64'(bus.stall), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("reset_rdata", 64'(bus.lane_rdata), 64'd0);
    chk("reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));

    for (int i = 0; i < 6; i++) begin
      do_txn(tab[i].we, tab[i].mask, tab[i].addr, tab[i].wdata, tab[i].rw, 0,
             tab[i].hold, 1'b1, tab[i].rd, tab[i].lat, tab[i].beats,
             $sformatf("tab%0d", i));
    end

    // Reset while a load waits in RESP.
    ready_wait = 0;
    resp_wait  = 6;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_mask  = 4'b1111;
    bus.lane_addr = {16'd3, 16'd2, 16'd1, 16'd0};
    @(posedge clk);
    reached = 0;
    for (int c = 0; c < 20 && reached == 0; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      if (bus.dbg_state === ST_RESP) reached = 1;
    end
    chk("rst_reach_resp", 64'(reached), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_mem_we_addr_wdata", {31'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'd0);
    chk("rst_done_stall", {62'd0, bus.done, bus.stall}, 64'd0);
    chk("rst_rdata", 64'(bus.lane_rdata), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    resp_pend = 1'b0;
    rdy_cnt   = 0;
    for (int t = 0; t < NT; t++) exp_rd[t] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 64'(bus.req_ready), 64'd1);
    do_txn(1'b0, 4'b1111, {16'd3, 16'd2, 16'd1, 16'd0}, 64'd0, 0, 0, 1'b0, 1'b1,
           {16'd13, 16'd12, 16'd11, 16'd10}, 9, 4, "post_rst");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [NT*DW-1:0] ra, rwd;
      for (int t = 0; t < NT; t++) begin
        ra[t*DW +: DW]  = DW'($urandom_range(0, 7));
        rwd[t*DW +: DW] = DW'($urandom);
      end
      do_txn(1'($urandom_range(0, 1)), NT'($urandom_range(0, 15)), ra, rwd,
             $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
             1'b0, 64'd0, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_sequencer.md
LSU_MEM_SEQUENCER -- requirements
Module: lsu_mem_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_THREADS, default 4, giving the number of SIMT lanes.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the address and data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  core issues an LDR/STR warp request.
REQ-006 req_we  input  1  1 = store (STR), 0 = load (LDR).
REQ-007 req_mask  input  NUM_THREADS  exec mask; bit t = lane t active.
REQ-008 lane_addr  input  NUM_THREADS x DATA_WIDTH  per-lane address.
REQ-009 lane_wdata  input  NUM_THREADS x DATA_WIDTH  per-lane store data.
REQ-010 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-011 stall  output  1  core must hold PC and decode.
REQ-012 done  output  1  one-cycle pulse, warp request complete.
REQ-013 lane_rdata  output  NUM_THREADS x DATA_WIDTH  per-lane load result.
REQ-014 mem_valid / mem_ready  output / input  1 each  single memory-port request handshake.
REQ-015 mem_addr / mem_wdata  output  DATA_WIDTH each  memory-port address and store data.
REQ-016 mem_we  output  1  memory-port write enable.
REQ-017 mem_rvalid / mem_rdata  input  1 / DATA_WIDTH  memory-port read response.

Function
REQ-018 The block SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-019 IDLE: req_ready=1 and stall=0; on req_valid, the block SHALL latch req_we, req_mask (as pending mask), lane_addr and lane_wdata; next state is REQ, or DONE if the mask is zero.
REQ-020 REQ: the block SHALL select the lowest-index pending lane and drive mem_valid=1 with that lane's addr, wdata and the latched we, all held stable until mem_ready.
REQ-021 REQ store with mem_ready: the block SHALL clear the lane bit and go to REQ if bits remain, else DONE.
REQ-022 REQ load with mem_ready: the block SHALL go to RESP.
REQ-023 RESP: on mem_rvalid, the block SHALL write mem_rdata to lane_rdata[lane] and clear the bit; next state follows the REQ-021 rule.
REQ-024 The block SHALL ignore mem_rvalid outside RESP.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 stall SHALL be 1 in REQ, RESP and DONE.
REQ-027 lane_rdata of inactive lanes, and all lanes on stores, SHALL hold their previous values.
REQ-028 req_valid while busy SHALL be ignored (req_ready=0); the request is not queued.
REQ-029 Latency with zero-wait memory (mem_ready=1, mem_rvalid in the cycle after issue): done asserts 2N+1 cycles after acceptance for N loads and N+1 cycles after for N stores.

Reset
REQ-030 Asserting rst_n low, including mid-transaction, SHALL immediately force IDLE, abandon any outstanding access, and zero mem_valid, mem_we, mem_addr, mem_wdata, done, stall, the pending mask and all lane_rdata.
REQ-031 After reset release, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-032 Macro LSU_COALESCE_EN: when defined, a load response SHALL also be written to every pending lane whose latched address equals the served lane's address, clearing all of those bits, so there is one memory access per distinct address. Stores are not coalesced.
REQ-033 When LSU_COALESCE_EN is undefined, the block SHALL make exactly one memory access per active lane.

Structure
REQ-034 The FSM state enum lsu_state_t SHALL live in the shared package gpu_isa_pkg.
REQ-035 Lowest-set-bit selection SHALL be a sub-module lane_pick (inputs: pending mask; outputs: index and any-valid flag).

Verification
REQ-036 Load, mask 1111, memory returns addr+10, addresses 0..3 -> lane_rdata = 10,11,12,13; done at cycle 9 after acceptance; stall high throughout.
REQ-037 Store, mask 0010, addr 5, wdata 22 -> exactly one mem_valid beat with addr=5, we=1, wdata=22; done 2 cycles after acceptance.
REQ-038 Load, mask 0000 -> no mem_valid; done pulses in the cycle after acceptance; lane_rdata unchanged.
REQ-039 Load, mask 1111, mem_ready held low 3 cycles -> mem_addr/mem_valid stable while stalled; second req_valid during busy is ignored.
REQ-040 rst_n pulsed low while in RESP -> all outputs 0 and IDLE; a new load afterwards completes normally.
REQ-041 With LSU_COALESCE_EN, load, mask 1111, all addresses 7 -> one memory access, all lanes get the same data; without the macro -> four accesses.
